// File: rtl/nn_layer_addr_seq.sv
// nn_layer_addr_seq: runtime BRAM address sequencer for up to four fully-connected
// layers. Layer bases are derived from the IN_k parameters at elaboration; each run
// issues weight/input read beats, a bias beat and a write-back request per layer.
// Ports:
//   Clk, Reset_n           clock (rising edge), asynchronous active-low reset
//   start/single/layer_sel run request (full run, or one layer in single mode)
//   addr_valid/addr_ready  read beat handshake; w_addr, io_addr, is_bias, first_beat
//   wb_valid/wb_ready      write-back handshake; wb_addr
//   layer_idx, busy        layer being sequenced, high outside IDLE
//   done, err              one-cycle pulses: run complete, start rejected
module nn_layer_addr_seq #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned IN_0       = 784,
  parameter int unsigned IN_1       = 20,
  parameter int unsigned IN_2       = 20,
  parameter int unsigned IN_3       = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic              single,
  input  logic [1:0]        layer_sel,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] w_addr,
  output logic [ADDR_W-1:0] io_addr,
  output logic              is_bias,
  output logic              first_beat,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [1:0]        layer_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Input count of layer k.
  function automatic int unsigned in_of(input int unsigned k);
    case (k)
      0:       return IN_0;
      1:       return IN_1;
      2:       return IN_2;
      default: return IN_3;
    endcase
  endfunction

  // Write-back (and weight) base of layer k: each earlier layer occupies IN+1 words.
  function automatic int unsigned wb_of(input int unsigned k);
    int unsigned acc;
    acc = 0;
    for (int unsigned j = 0; j < k; j++) acc += in_of(j) + 1;
    return acc;
  endfunction

  function automatic int unsigned max_in();
    int unsigned m;
    m = 0;
    for (int unsigned k = 0; k < 4; k++) if (in_of(k) > m) m = in_of(k);
    return m;
  endfunction

  function automatic bit any_active_zero();
    for (int unsigned k = 0; k < NUM_LAYERS && k < 4; k++) if (in_of(k) == 0) return 1'b1;
    return 1'b0;
  endfunction

  localparam int unsigned MAX_IN = max_in();
  localparam int unsigned IW     = (MAX_IN < 2) ? 1 : $clog2(MAX_IN);
  localparam int unsigned LAST_L = (NUM_LAYERS >= 1 && NUM_LAYERS <= 4) ? NUM_LAYERS - 1 : 0;
  localparam longint unsigned LAST_OUT = 64'(wb_of(LAST_L)) + 64'(in_of(LAST_L)) + 64'd1;
  localparam longint unsigned ADDR_LIM = 64'd1 << ADDR_W;

  if (NUM_LAYERS < 1 || NUM_LAYERS > 4) begin : g_chk_layers
    $error("nn_layer_addr_seq: NUM_LAYERS must be in 1..4");
  end
  if (LAST_OUT >= ADDR_LIM) begin : g_chk_fit
    $error("nn_layer_addr_seq: layer layout does not fit in ADDR_W bits");
  end
  if (any_active_zero()) begin : g_chk_in
    $error("nn_layer_addr_seq: active layer has zero inputs");
  end

  // Per-layer address tables; input base of layer 0 is 0, later layers read the
  // previous layer's outputs, which start at their own write-back base.
  localparam logic [ADDR_W-1:0] WB_A [4] = '{
    ADDR_W'(wb_of(0)), ADDR_W'(wb_of(1)), ADDR_W'(wb_of(2)), ADDR_W'(wb_of(3))};
  localparam logic [ADDR_W-1:0] IO_A [4] = '{
    ADDR_W'(0), ADDR_W'(wb_of(1)), ADDR_W'(wb_of(2)), ADDR_W'(wb_of(3))};
  localparam logic [ADDR_W-1:0] BIAS_A [4] = '{
    ADDR_W'(wb_of(0) + in_of(0)), ADDR_W'(wb_of(1) + in_of(1)),
    ADDR_W'(wb_of(2) + in_of(2)), ADDR_W'(wb_of(3) + in_of(3))};
  localparam logic [ADDR_W-1:0] OUT_A [4] = '{
    ADDR_W'(wb_of(0) + in_of(0) + 1), ADDR_W'(wb_of(1) + in_of(1) + 1),
    ADDR_W'(wb_of(2) + in_of(2) + 1), ADDR_W'(wb_of(3) + in_of(3) + 1)};
  localparam logic [IW-1:0] LAST_I_A [4] = '{
    IW'(in_of(0) - 1), IW'(in_of(1) - 1), IW'(in_of(2) - 1), IW'(in_of(3) - 1)};

  typedef enum logic [2:0] {S_IDLE, S_RD, S_BIAS, S_WB, S_DONE} state_t;

  state_t            r_state, w_n_state;
  logic [1:0]        r_k, w_n_k;
  logic [IW-1:0]     r_i, w_n_i;
  logic              r_single, w_n_single;
  logic              r_addr_valid, w_n_addr_valid;
  logic [ADDR_W-1:0] r_w_addr, w_n_w_addr;
  logic [ADDR_W-1:0] r_io_addr, w_n_io_addr;
  logic              r_is_bias, w_n_is_bias;
  logic              r_first, w_n_first;
  logic              r_wb_valid, w_n_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr, w_n_wb_addr;
  logic              r_busy, w_n_busy;
  logic              r_done, w_n_done;
  logic              r_err, w_n_err;

  // State register; outputs are registered copies of the next-state decode.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_i          <= '0;
      r_single     <= 1'b0;
      r_addr_valid <= 1'b0;
      r_w_addr     <= '0;
      r_io_addr    <= '0;
      r_is_bias    <= 1'b0;
      r_first      <= 1'b0;
      r_wb_valid   <= 1'b0;
      r_wb_addr    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_n_state;
      r_k          <= w_n_k;
      r_i          <= w_n_i;
      r_single     <= w_n_single;
      r_addr_valid <= w_n_addr_valid;
      r_w_addr     <= w_n_w_addr;
      r_io_addr    <= w_n_io_addr;
      r_is_bias    <= w_n_is_bias;
      r_first      <= w_n_first;
      r_wb_valid   <= w_n_wb_valid;
      r_wb_addr    <= w_n_wb_addr;
      r_busy       <= w_n_busy;
      r_done       <= w_n_done;
      r_err        <= w_n_err;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    w_n_state  = r_state;
    w_n_k      = r_k;
    w_n_i      = r_i;
    w_n_single = r_single;
    w_n_err    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (single && (3'(layer_sel) >= 3'(NUM_LAYERS))) begin
            w_n_err = 1'b1;
          end else begin
            w_n_state  = S_RD;
            w_n_k      = single ? layer_sel : 2'd0;
            w_n_i      = '0;
            w_n_single = single;
          end
        end
      end
      S_RD: begin
        if (addr_ready) begin
          if (r_i == LAST_I_A[r_k]) w_n_state = S_BIAS;
          else                      w_n_i     = r_i + IW'(1);
        end
      end
      S_BIAS: begin
        if (addr_ready) w_n_state = S_WB;
      end
      S_WB: begin
        if (wb_ready) begin
          if (r_single || (r_k == 2'(NUM_LAYERS - 1))) begin
            w_n_state = S_DONE;
          end else begin
            w_n_state = S_RD;
            w_n_k     = r_k + 2'd1;
            w_n_i     = '0;
          end
        end
      end
      S_DONE:  w_n_state = S_IDLE;
      default: w_n_state = S_IDLE;
    endcase

    w_n_addr_valid = (w_n_state == S_RD) || (w_n_state == S_BIAS);
    w_n_is_bias    = (w_n_state == S_BIAS);
    w_n_first      = (w_n_state == S_RD) && (w_n_i == '0);
    w_n_wb_valid   = (w_n_state == S_WB);
    w_n_busy       = (w_n_state != S_IDLE);
    w_n_done       = (w_n_state == S_DONE);

    // Addresses hold outside the states that drive them (io_addr holds through BIAS).
    w_n_w_addr  = r_w_addr;
    w_n_io_addr = r_io_addr;
    w_n_wb_addr = r_wb_addr;
    if (w_n_state == S_RD) begin
      w_n_w_addr  = WB_A[w_n_k] + ADDR_W'(w_n_i);
      w_n_io_addr = IO_A[w_n_k] + ADDR_W'(w_n_i);
    end else if (w_n_state == S_BIAS) begin
      w_n_w_addr  = BIAS_A[w_n_k];
    end else if (w_n_state == S_WB) begin
      w_n_wb_addr = OUT_A[w_n_k];
    end
  end

  assign addr_valid = r_addr_valid;
  assign w_addr     = r_w_addr;
  assign io_addr    = r_io_addr;
  assign is_bias    = r_is_bias;
  assign first_beat = r_first;
  assign wb_valid   = r_wb_valid;
  assign wb_addr    = r_wb_addr;
  assign layer_idx  = r_k;
  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;

endmodule
